// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 stream controller.
package lz77_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        FLUSH_WAIT
    } ctrl_state_t;

    localparam int ERR_ZERO_WORD = 0;
    localparam int ERR_TIMEOUT   = 1;

    // Token packs {distance, length, literal}.
    function automatic int tok_width(input int q_bits, input int la_bits);
        return (q_bits + 1) + (la_bits + 1) + 8;
    endfunction

endpackage

// File: rtl/lz77_stream_ctrl_if.sv
// Upstream word stream and downstream token stream of the LZ77 controller.
interface lz77_stream_ctrl_if #(
    parameter int TOK_W = 27
);
    // Both streams: a beat transfers on a clock edge where valid & ready are
    // both high; valid never depends on ready, ready may depend on valid.
    logic [63:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [TOK_W-1:0] tok_data;
    logic             tok_valid;
    logic             tok_ready;

    modport master (
        output in_data, in_valid, in_last, tok_ready,
        input  in_ready, tok_data, tok_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, tok_ready,
        output in_ready, tok_data, tok_valid
    );

endinterface

// File: rtl/lz77_stream_ctrl_tok_fifo.sv
// Show-ahead token FIFO; a push while full is taken only if a pop frees a slot.
module lz77_tok_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic                     full,
    output logic                     accepted,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign pop_ok   = pop & ~empty;
    assign accepted = push & (~full | pop_ok);
    assign head     = mem_q[rd_q];
    assign count    = cnt_q;

    always_comb begin
        wr_d  = wr_q + AW'(accepted);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + CW'(accepted) - CW'(pop_ok);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accepted) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/lz77_stream_ctrl.sv
// Sequences one LZ77 compressor: forwards words, flushes at frame end, buffers tokens.
// Define LZ77_CTRL_STATS_EN to add per-frame word/token statistics outputs.
module lz77_stream_ctrl
    import lz77_pkg::*;
#(
    parameter int Q_BITS        = 10,
    parameter int LA_BITS       = 7,
    parameter int FIFO_DEPTH    = 16,
    parameter int STALL_SLACK   = 3,
    parameter int FLUSH_TIMEOUT = 4095
) (
    input  logic                 clock,
    input  logic                 reset,
    lz77_stream_ctrl_if.slave    bus,
    output logic [63:0]          comp_bytes_in,
    output logic                 comp_bytes_in_valid,
    input  logic                 comp_buffer_ready,
    output logic                 comp_stall,
    input  logic [Q_BITS:0]      comp_distance,
    input  logic [LA_BITS:0]     comp_length,
    input  logic [7:0]           comp_literal,
    input  logic                 comp_output_valid,
    input  logic                 comp_dumping_finished,
    output logic                 frame_done,
    output logic [1:0]           err,
    output ctrl_state_t          state_dbg
`ifdef LZ77_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_tokens,
    output logic [31:0]          stat_lit_tokens
`endif
);
    localparam int TOK_W = tok_width(Q_BITS, LA_BITS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

    ctrl_state_t       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              stall_q, stall_d;
    logic              xfer, in_ready_w;
    logic              fifo_empty, fifo_full, tok_push_ok, tok_pop;
    logic [CNT_W-1:0]  fifo_count, cnt_nxt;

    lz77_tok_fifo #(.W(TOK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (comp_output_valid),
        .push_data ({comp_distance, comp_length, comp_literal}),
        .pop       (bus.tok_ready),
        .head      (bus.tok_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .accepted  (tok_push_ok),
        .count     (fifo_count)
    );

    assign bus.tok_valid = ~fifo_empty;
    assign tok_pop       = bus.tok_ready & ~fifo_empty;
    assign cnt_nxt       = fifo_count + CNT_W'(tok_push_ok) - CNT_W'(tok_pop);
    assign xfer          = (state_q == STREAM) & bus.in_valid & comp_buffer_ready;

    always_comb begin
        state_d             = state_q;
        tmr_d               = '0;
        done_d              = 1'b0;
        err_d               = err_q;
        in_ready_w          = 1'b0;
        comp_bytes_in_valid = 1'b0;
        comp_bytes_in       = '0;
        // Stall looks at the occupancy after this edge so it reacts without lag.
        stall_d             = (FIFO_DEPTH - int'(cnt_nxt)) < STALL_SLACK;
        case (state_q)
            IDLE: state_d = STREAM;
            STREAM: begin
                in_ready_w          = comp_buffer_ready;
                comp_bytes_in_valid = xfer;
                comp_bytes_in       = xfer ? bus.in_data : '0;
                if (xfer) begin
                    // All-zero is the compressor's flush marker, never legal data.
                    if (bus.in_data == '0) err_d[ERR_ZERO_WORD] = 1'b1;
                    if (bus.in_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                comp_bytes_in_valid = 1'b1;
                if (comp_buffer_ready) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (comp_dumping_finished) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == TMR_W'(FLUSH_TIMEOUT)) begin
                    done_d              = 1'b1;
                    err_d[ERR_TIMEOUT]  = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready = in_ready_w;
    assign comp_stall   = stall_q;
    assign frame_done   = done_q;
    assign err          = err_q;
    assign state_dbg    = state_q;

`ifdef LZ77_CTRL_STATS_EN
    logic [31:0] words_q, words_d, toks_q, toks_d, lits_q, lits_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        words_d = done_q ? '0 : sat_inc(words_q, xfer);
        toks_d  = done_q ? '0 : sat_inc(toks_q, tok_push_ok);
        lits_d  = done_q ? '0 : sat_inc(lits_q, tok_push_ok & (comp_length == (LA_BITS+1)'(1)));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            words_q <= '0;
            toks_q  <= '0;
            lits_q  <= '0;
        end else begin
            words_q <= words_d;
            toks_q  <= toks_d;
            lits_q  <= lits_d;
        end
    end

    assign stat_words      = words_q;
    assign stat_tokens     = toks_q;
    assign stat_lit_tokens = lits_q;
`endif

endmodule

// File: tb/tb_lz77_stream_ctrl.sv
// Bench for lz77_stream_ctrl: cycle reference model plus directed literal pins.
module tb_lz77_stream_ctrl;
    import lz77_pkg::*;

    localparam int Q_BITS  = 10;
    localparam int LA_BITS = 7;
    localparam int DEPTH   = 16;
    localparam int SLACK   = 3;
    localparam int TMO     = 15;
    localparam int TOK_W   = Q_BITS + LA_BITS + 10;

    localparam int P_GAP = 0, P_ACC = 1, P_FLUSH = 2, P_WAIT = 3;

    // ---------------- clock / reset ----------------
    logic clock, reset;
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [63:0]        in_data;
    logic               in_valid, in_last, tok_ready;
    logic               comp_buffer_ready, comp_output_valid, comp_dumping_finished;
    logic [Q_BITS:0]    comp_distance;
    logic [LA_BITS:0]   comp_length;
    logic [7:0]         comp_literal;
    logic [63:0]        comp_bytes_in;
    logic               comp_bytes_in_valid, comp_stall, frame_done;
    logic [1:0]         err;
    ctrl_state_t        state_dbg;

    lz77_stream_ctrl_if #(.TOK_W(TOK_W)) ifc ();
    assign ifc.in_data   = in_data;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_last   = in_last;
    assign ifc.tok_ready = tok_ready;

    lz77_stream_ctrl #(
        .Q_BITS(Q_BITS), .LA_BITS(LA_BITS), .FIFO_DEPTH(DEPTH),
        .STALL_SLACK(SLACK), .FLUSH_TIMEOUT(TMO)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .bus                   (ifc.slave),
        .comp_bytes_in         (comp_bytes_in),
        .comp_bytes_in_valid   (comp_bytes_in_valid),
        .comp_buffer_ready     (comp_buffer_ready),
        .comp_stall            (comp_stall),
        .comp_distance         (comp_distance),
        .comp_length           (comp_length),
        .comp_literal          (comp_literal),
        .comp_output_valid     (comp_output_valid),
        .comp_dumping_finished (comp_dumping_finished),
        .frame_done            (frame_done),
        .err                   (err),
        .state_dbg             (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [TOK_W-1:0] exp_q[$];
    int   m_phase, m_wait, m_sz;
    logic [1:0] m_err;
    bit   m_done, m_stall, m_live, m_pop, m_push;

    initial begin
        m_live = 1'b0;
        forever begin
            @(posedge clock);
            if (!reset) begin
                exp_q.delete();
                m_phase = P_GAP;
                m_wait  = 0;
                m_err   = 2'b00;
                m_done  = 1'b0;
                m_stall = 1'b0;
                m_live  = 1'b1;
            end else if (m_live) begin
                m_sz   = exp_q.size();
                m_pop  = (m_sz > 0) && tok_ready;
                m_push = comp_output_valid && (m_sz < DEPTH || m_pop);
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) exp_q.push_back({comp_distance, comp_length, comp_literal});
                m_stall = (DEPTH - exp_q.size()) < SLACK;
                m_done  = 1'b0;
                case (m_phase)
                    P_GAP: m_phase = P_ACC;
                    P_ACC: if (in_valid && comp_buffer_ready) begin
                        if (in_data == 64'd0) m_err[0] = 1'b1;
                        if (in_last) m_phase = P_FLUSH;
                    end
                    P_FLUSH: if (comp_buffer_ready) begin
                        m_phase = P_WAIT;
                        m_wait  = 0;
                    end
                    default: begin
                        if (comp_dumping_finished) begin
                            m_done = 1'b1; m_phase = P_GAP;
                        end else if (m_wait == TMO) begin
                            m_done = 1'b1; m_err[1] = 1'b1; m_phase = P_GAP;
                        end else m_wait++;
                    end
                endcase
            end
        end
    end

    bit c_rdy, c_cv;
    initial forever begin
        @(negedge clock);
        if (m_live) begin
            c_rdy = (m_phase == P_ACC) && comp_buffer_ready;
            c_cv  = (m_phase == P_ACC) ? (in_valid && comp_buffer_ready) : (m_phase == P_FLUSH);
            chk("in_ready", ifc.in_ready, c_rdy);
            chk("comp_valid", comp_bytes_in_valid, c_cv);
            if (c_cv) chk("comp_data", comp_bytes_in, (m_phase == P_FLUSH) ? 64'd0 : in_data);
            chk("tok_valid", ifc.tok_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) chk("tok_data", ifc.tok_data, exp_q[0]);
            chk("comp_stall", comp_stall, m_stall);
            chk("err", err, m_err);
            chk("frame_done", frame_done, m_done);
        end
    end

    // ---------------- drivers ----------------
    bit bg_en = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] d, input bit last);
        int  n;
        bit  acc;
        in_data = d; in_valid = 1'b1; in_last = last;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = ifc.in_ready;
            n++;
        end
        chk("accept_in_time", acc, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Waits for the flush handshake, then optionally reports dump completion.
    task automatic end_frame(input int delay, input bit give_done);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clock);
            seen = comp_bytes_in_valid && comp_buffer_ready;
            n++;
        end
        chk("flush_in_time", seen, 1'b1);
        tick();
        repeat (delay) tick();
        if (give_done) begin
            comp_dumping_finished = 1'b1;
            tick();
            comp_dumping_finished = 1'b0;
        end
    endtask

    task automatic put_tok(input int i);
        comp_output_valid = 1'b1;
        comp_distance     = (Q_BITS+1)'(i + 1);
        comp_length       = (LA_BITS+1)'(i + 2);
        comp_literal      = 8'hA0 + 8'(i);
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        if (bg_en) begin
            comp_output_valid = ($urandom_range(99) < 40) && (!comp_stall || $urandom_range(9) == 0);
            comp_distance     = (Q_BITS+1)'($urandom);
            comp_length       = (LA_BITS+1)'($urandom_range(3) == 0 ? 1 : $urandom);
            comp_literal      = 8'($urandom);
            tok_ready         = $urandom_range(99) < 60;
            comp_buffer_ready = $urandom_range(99) < 75;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; in_data = '0; in_valid = 0; in_last = 0; tok_ready = 0;
        comp_buffer_ready = 1; comp_output_valid = 0; comp_dumping_finished = 0;
        comp_distance = '0; comp_length = '0; comp_literal = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", ifc.in_ready, 1'b0);
        chk("rst_tok_valid", ifc.tok_valid, 1'b0);
        chk("rst_err", err, 2'b00);
        chk("rst_stall", comp_stall, 1'b0);
        chk("rst_state", state_dbg, IDLE);

        // Three-word frame, dump complete five cycles after the flush write.
        send_word(64'h1111_2222_3333_4444, 1'b0);
        send_word(64'h5555_6666_7777_8888, 1'b0);
        send_word(64'h9999_AAAA_BBBB_CCCC, 1'b1);
        #1;
        chk("flush_valid", comp_bytes_in_valid, 1'b1);
        chk("flush_data", comp_bytes_in, 64'd0);
        end_frame(4, 1'b1);
        #1;
        chk("done_pulse", frame_done, 1'b1);
        chk("done_state", state_dbg, IDLE);
        tick();
        #1;
        chk("done_single", frame_done, 1'b0);

        // Compressor not ready for four cycles mid-frame; stray dump pulse ignored.
        send_word(64'hDEAD_BEEF_0000_0001, 1'b0);
        comp_buffer_ready = 1'b0;
        in_data = 64'hCAFE_F00D_0000_0002; in_valid = 1'b1;
        comp_dumping_finished = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_in_ready", ifc.in_ready, 1'b0);
            chk("hold_comp_valid", comp_bytes_in_valid, 1'b0);
            tick();
            comp_dumping_finished = 1'b0;
        end
        chk("hold_state", state_dbg, STREAM);
        comp_buffer_ready = 1'b1;
        send_word(64'hCAFE_F00D_0000_0002, 1'b1);
        end_frame(2, 1'b1);

        // Fill to 14 tokens with no consumer, then pop one.
        tok_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            put_tok(i);
            tick();
            #1;
            if (i == 12) chk("stall_at_13", comp_stall, 1'b0);
            if (i == 13) chk("stall_at_14", comp_stall, 1'b1);
        end
        comp_output_valid = 1'b0;
        chk("head_tok0", ifc.tok_data, {11'd1, 8'd2, 8'hA0});
        tok_ready = 1'b1;
        tick();
        tok_ready = 1'b0;
        #1;
        chk("stall_release", comp_stall, 1'b0);
        chk("head_tok1", ifc.tok_data, {11'd2, 8'd3, 8'hA1});
        tok_ready = 1'b1;
        repeat (14) tick();
        tok_ready = 1'b0;
        #1;
        chk("drained", ifc.tok_valid, 1'b0);

        // Zero data word mid-frame.
        send_word(64'd0, 1'b0);
        #1;
        chk("zero_word_err", err, 2'b01);
        send_word(64'h0000_0000_0000_1234, 1'b1);
        end_frame(0, 1'b1);
        #1;
        chk("zero_err_sticky", err, 2'b01);
        chk("zero_frame_done", frame_done, 1'b1);

        // Flush timeout: no dump completion at all.
        do_reset();
        send_word(64'h0000_0000_0000_ABCD, 1'b1);
        repeat (16) tick();
        #1;
        chk("tmo_not_yet", frame_done, 1'b0);
        chk("tmo_err_clear", err, 2'b00);
        tick();
        #1;
        chk("tmo_done", frame_done, 1'b1);
        chk("tmo_err", err, 2'b10);
        chk("tmo_state", state_dbg, IDLE);
        tick();
        #1;
        chk("tmo_done_single", frame_done, 1'b0);

        // Reset with tokens buffered during STREAM.
        for (int i = 0; i < 5; i++) begin
            put_tok(i + 20);
            tick();
        end
        comp_output_valid = 1'b0;
        #1;
        chk("pre_rst_tok_valid", ifc.tok_valid, 1'b1);
        reset = 1'b0;
        tick();
        #1;
        chk("mid_rst_tok_valid", ifc.tok_valid, 1'b0);
        chk("mid_rst_in_ready", ifc.in_ready, 1'b0);
        chk("mid_rst_err", err, 2'b00);
        chk("mid_rst_stall", comp_stall, 1'b0);
        chk("mid_rst_cdata", comp_bytes_in, 64'd0);
        reset = 1'b1;

        // Randomised frames against the model.
        bg_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_word(($urandom_range(14) == 0) ? 64'd0 : {$urandom, $urandom} | 64'd1,
                          w == nw - 1);
            end
            end_frame($urandom_range(0, 8), $urandom_range(4) != 0);
        end
        repeat (20) tick();
        bg_en = 1'b0;
        tick();
        comp_output_valid = 1'b0;
        tok_ready = 1'b1;
        repeat (20) tick();
        #1;
        chk("final_drain", ifc.tok_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
